pcie_gen3_lane_descrambler: RTL
===============================

Name: pcie_gen3_lane_descrambler

Overview:
- Multi-lane 128b/130b receive descrambler; the next generation of the single-lane 8b/10b-era descrambler in the PCIe PHY RX path.
- Sits between block alignment / sync-header strip and the lane deskew / ordered-set decoder.
- Keeps one 23-bit Gen3 LFSR per lane.
- Descrambles data blocks and bypasses ordered sets.
- Holds the LFSR for SKP, reseeds it after EIEOS, and flags sync-header and block-alignment errors.

Parameters:
- NUM_LANES, 4, lane count; legal 1..8.
- LANE_BYTES, 4, bytes per lane per beat; legal 1, 2, 4, 8, 16.
- BEATS_PER_BLOCK, 16/LANE_BYTES, derived (localparam); beats per 130-bit block.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_data  in  NUM_LANES*LANE_BYTES*8  lane n occupies bits [n*LANE_BYTES*8 +: LANE_BYTES*8]; byte 0 is earliest
- in_block_start  in  1  first beat of a block
- in_sync_hdr  in  2  block sync header, sampled when in_block_start=1
- in_reseed  in  1  force all LFSRs to seed (LTSSM entry to Recovery/L0)
- out_valid  out  1  registered in_valid
- out_data  out  NUM_LANES*LANE_BYTES*8  descrambled or bypassed data
- out_block_start  out  1  registered in_block_start
- out_sync_hdr  out  2  registered block sync header
- out_sync_err  out  1  one-cycle pulse: illegal sync header
- out_align_err  out  1  one-cycle pulse: block start at wrong beat

Behaviour:
- Latency: exactly 1 cycle, in to out, for every output. No backpressure.
- Reset values:
  - all out_* = 0;
  - lane n LFSR = seed[n];
  - beat counter = 0;
  - block type = DATA.
- Seeds (hex), lanes 0..7: 1DBFBC, 0607BB, 1EC760, 18C0DB, 010F12, 19CFC9, 0277CE, 1BB807.
- LFSR (Galois, x^23+x^21+x^16+x^8+x^5+x^2+1), per bit:
  - key bit = lfsr[22];
  - next = {lfsr[21:0],1'b0} ^ (lfsr[22] ? 23'h210125 : 0).
  - Bits are processed LSB-first within a byte, bytes in ascending order.
  - One beat advances each LFSR by LANE_BYTES*8 bits; the combinational unroll happens in one cycle.
- Block type is latched on in_valid & in_block_start, from in_sync_hdr and lane 0 byte 0:
  - 2'b10 -> DATA;
  - 2'b01 with byte 0xAA -> SKP;
  - 2'b01 with byte 0x00 -> EIEOS;
  - other 2'b01 -> OS;
  - 2'b00 or 2'b11 -> BAD.
  - The latched type applies to the start beat and to all following beats of the block.
- Per-type action on each valid beat:
  - DATA: out = in XOR keystream; LFSR advances.
  - OS: out = in (bypass); LFSR advances.
  - SKP: bypass; LFSR holds.
  - EIEOS: bypass; LFSR advances; on the last beat (counter = BEATS_PER_BLOCK-1), the LFSR loads its seed instead.
  - BAD: bypass; LFSR holds; out_sync_err pulses once, on the start beat.
- Beat counter:
  - increments on in_valid;
  - wraps to 0 after BEATS_PER_BLOCK-1;
  - in_block_start forces the beat to be treated as beat 0.
- in_block_start=1 while counter ≠ 0:
  - out_align_err pulses;
  - the counter realigns;
  - the new block is processed normally.
- Counter = 0 without in_block_start: out_align_err pulses and the previous block type is reused.
- in_valid=0: LFSR, counter and type hold; out_valid=0; out_data holds its previous value.
- in_reseed: all LFSRs load seed on the next edge, regardless of in_valid. It has priority over advance and over EIEOS reseed on the same cycle. Data on that beat uses the pre-reseed LFSR.
- NUM_LANES=1 and LANE_BYTES=16 (one beat per block, counter constant 0) must both be legal.
- Asynchronous reset mid-block returns all state to the reset values immediately.

Test Plan:
- Round-trip: after reset, feed 8 DATA blocks of all-zero bytes and capture the keystream. After a second reset, feed the captured keystream as DATA -> out_data all zero. Lane 0 keystream must match the bit-serial model seeded with 1DBFBC.
- SKP hold: DATA, SKP (bytes 0xAA), DATA -> SKP beats pass unchanged. The second DATA block's keystream equals the continuation as if the SKP block were absent.
- EIEOS reseed: DATA×3, EIEOS (byte 0x00), DATA -> the DATA block after EIEOS gets the same keystream as the first block after reset, on every lane.
- Bad header: in_sync_hdr=2'b11 on a block start -> out_sync_err=1 for one cycle, 1 cycle later. Data is bypassed, and the next DATA keystream shows no LFSR advance.
- Misalignment: with LANE_BYTES=4, assert in_block_start at beat 2 -> out_align_err pulse; the counter restarts, and the next start at +4 beats gives no error.
- Stalls/reseed: randomise in_valid gaps → keystream identical to gap-free run; assert in_reseed together with an EIEOS last beat → exactly one reseed, and the following block matches the post-reset keystream.

Source files
------------

// File: rtl/pcie_gen3_lane_descrambler.sv
// pcie_gen3_lane_descrambler: multi-lane PCIe Gen3 128b/130b receive descrambler.
// Keeps one 23-bit Galois LFSR per lane. DATA blocks are XORed with the keystream.
// Ordered sets are bypassed: SKP and bad-header blocks freeze the LFSR, and EIEOS
// reloads the seed on its last beat. All outputs are registered (1-cycle latency).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   in_valid        beat valid (no backpressure)
//   in_data         lane n at [n*LANE_BYTES*8 +: LANE_BYTES*8], byte 0 earliest
//   in_block_start  first beat of a 130-bit block
//   in_sync_hdr     block sync header, sampled with in_block_start
//   in_reseed       load every LFSR with its seed on the next edge
//   out_valid, out_data, out_block_start, out_sync_hdr  registered beat
//   out_sync_err    pulse: illegal sync header on a block start
//   out_align_err   pulse: block start seen at the wrong beat position
module pcie_gen3_lane_descrambler #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_BYTES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [NUM_LANES*LANE_BYTES*8-1:0] in_data,
    input  logic                              in_block_start,
    input  logic [1:0]                        in_sync_hdr,
    input  logic                              in_reseed,
    output logic                              out_valid,
    output logic [NUM_LANES*LANE_BYTES*8-1:0] out_data,
    output logic                              out_block_start,
    output logic [1:0]                        out_sync_hdr,
    output logic                              out_sync_err,
    output logic                              out_align_err
);
    localparam int BEATS_PER_BLOCK = 16 / LANE_BYTES;
    localparam int LW = LANE_BYTES * 8;
    localparam int W = NUM_LANES * LW;
    localparam int CW = BEATS_PER_BLOCK > 1 ? $clog2(BEATS_PER_BLOCK) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS_PER_BLOCK - 1);
    localparam logic [8*23-1:0] SEEDS = {23'h1BB807, 23'h0277CE, 23'h19CFC9, 23'h010F12,
                                         23'h18C0DB, 23'h1EC760, 23'h0607BB, 23'h1DBFBC};
    localparam logic [2:0] T_DATA = 3'd0, T_OS = 3'd1, T_SKP = 3'd2, T_EIEOS = 3'd3, T_BAD = 3'd4;

    logic [2:0]    blk_type, blk_type_nxt, hdr_type, cur_type;
    logic [CW-1:0] cnt, cnt_nxt, beat;
    logic          hold, eieos_end;
    logic [W-1:0]  keystream;

    // Classify a block from its sync header and the first symbol of lane 0.
    assign hdr_type = in_sync_hdr == 2'b10 ? T_DATA :
                      in_sync_hdr == 2'b01 ? (in_data[7:0] == 8'hAA ? T_SKP :
                                              in_data[7:0] == 8'h00 ? T_EIEOS : T_OS) : T_BAD;
    // A start beat always counts as beat 0 and uses its own header; other beats
    // inherit the type of the block in progress.
    assign cur_type  = in_block_start ? hdr_type : blk_type;
    assign beat      = in_block_start ? '0 : cnt;
    assign hold      = cur_type == T_SKP || cur_type == T_BAD;
    assign eieos_end = cur_type == T_EIEOS && beat == LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_type <= T_DATA;
            cnt      <= '0;
        end else begin
            blk_type <= blk_type_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        blk_type_nxt = in_valid ? cur_type : blk_type;
        cnt_nxt      = !in_valid ? cnt : beat == LAST ? '0 : beat + CW'(1);
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        localparam logic [22:0] SEED = SEEDS[n*23 +: 23];
        logic [22:0]   lfsr, lfsr_adv;
        logic [LW-1:0] ks;

        // Whole-beat unroll: bit i of the lane word takes key bit i, LSB-first per byte.
        always_comb begin
            lfsr_adv = lfsr;
            ks       = '0;
            for (int i = 0; i < LW; i++) begin
                ks[i]    = lfsr_adv[22];
                lfsr_adv = {lfsr_adv[21:0], 1'b0} ^ (lfsr_adv[22] ? 23'h210125 : 23'h0);
            end
        end

        // Reseed wins over everything, including the EIEOS reload on the same edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) lfsr <= SEED;
            else if (in_reseed) lfsr <= SEED;
            else if (in_valid && !hold) lfsr <= eieos_end ? SEED : lfsr_adv;
        end

        assign keystream[n*LW +: LW] = ks;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_block_start <= 1'b0;
            out_sync_hdr    <= 2'b00;
            out_sync_err    <= 1'b0;
            out_align_err   <= 1'b0;
        end else begin
            out_valid       <= in_valid;
            out_block_start <= in_block_start;
            out_sync_hdr    <= in_sync_hdr;
            out_sync_err    <= in_valid && in_block_start && (in_sync_hdr == 2'b00 || in_sync_hdr == 2'b11);
            out_align_err   <= in_valid && (in_block_start ? cnt != '0 : cnt == '0);
            if (in_valid) out_data <= cur_type == T_DATA ? in_data ^ keystream : in_data;
        end
    end
endmodule
